// File: rtl/i2s_master_ctrl.sv
// i2s_master_ctrl: I2S bus master (bclk/lrclk generation) and MSB-first frame serialiser fed by a one-frame holding buffer.
// Define I2S_REPEAT_ON_UNDERRUN_EN to resend the previous frame on underrun instead of silence.
module i2s_master_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    bclk_o,
    output logic                    lrclk_o,
    output logic                    dacda_o,
    output logic                    frame_start,
    output logic                    underrun,
    output logic                    busy
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_MAX  = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] LR_LO    = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] LR_HI    = BW'(2 * SLOT_WIDTH - 2);
    localparam logic [SAMPLE_WIDTH-1:0] MSB = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
`ifdef I2S_REPEAT_ON_UNDERRUN_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t r_state, w_state_nx;

    logic [DW-1:0]           r_div_cnt, w_div_nx;
    logic [BW-1:0]           r_bit_cnt, w_bit_nx, w_pos;
    logic [SAMPLE_WIDTH-1:0] r_hold_l, r_hold_r, r_left, r_right;
    logic [SAMPLE_WIDTH-1:0] w_left_nx, w_right_nx, w_word;
    logic                    r_hold_empty, r_bclk, r_lrclk, r_dacda, r_frame_start, r_underrun, r_busy;
    logic                    w_fall, w_wrap, w_load, w_run_nx, w_acc, w_dbit;

    assign w_fall   = (r_state != IDLE) && (r_div_cnt == DIV_MAX);
    assign w_wrap   = w_fall && (r_bit_cnt == BIT_MAX);
    assign w_run_nx = (w_state_nx != IDLE);
    assign w_acc    = in_valid && r_hold_empty;

    // A wrap with enable low ends the frame sequence without loading.
    always_comb begin
        w_load     = (r_state == IDLE) ? enable : (w_wrap && enable);
        w_state_nx = !enable ? ((r_state == IDLE || w_wrap) ? IDLE : DRAIN) : RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    assign w_div_nx   = (r_state == IDLE || !w_run_nx || w_fall) ? '0 : r_div_cnt + 1'b1;
    assign w_bit_nx   = (!w_run_nx || w_load) ? '0 : (w_fall ? r_bit_cnt + 1'b1 : r_bit_cnt);
    assign w_left_nx  = !w_load ? r_left  : (!r_hold_empty ? r_hold_l : (REPEAT ? r_left  : '0));
    assign w_right_nx = !w_load ? r_right : (!r_hold_empty ? r_hold_r : (REPEAT ? r_right : '0));
    // Slot bit positions past the sample width shift the mask out and serialise as zero.
    assign w_word     = (w_bit_nx < SLOT) ? w_left_nx : w_right_nx;
    assign w_pos      = (w_bit_nx < SLOT) ? w_bit_nx : w_bit_nx - SLOT;
    assign w_dbit     = |(w_word & (MSB >> w_pos));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_left        <= '0;
            r_right       <= '0;
            r_hold_empty  <= 1'b1;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_dacda       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_nx;
            r_bit_cnt     <= w_bit_nx;
            r_left        <= w_left_nx;
            r_right       <= w_right_nx;
            r_hold_empty  <= w_acc ? 1'b0 : (w_load ? 1'b1 : r_hold_empty);
            r_bclk        <= w_run_nx && (w_div_nx >= DIV_HALF);
            r_lrclk       <= w_run_nx && (w_bit_nx >= LR_LO) && (w_bit_nx <= LR_HI);
            r_dacda       <= !w_run_nx ? 1'b0 : ((w_load || w_fall) ? w_dbit : r_dacda);
            r_frame_start <= w_load;
            r_underrun    <= w_load && r_hold_empty;
            r_busy        <= w_run_nx;
            if (w_acc) begin
                r_hold_l <= left_in;
                r_hold_r <= right_in;
            end
        end
    end

    assign in_ready    = r_hold_empty;
    assign bclk_o      = r_bclk;
    assign lrclk_o     = r_lrclk;
    assign dacda_o     = r_dacda;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign busy        = r_busy;
endmodule

// File: tb/tb_i2s_master_ctrl.sv
// tb_i2s_master_ctrl: directed bench for i2s_master_ctrl with SW=16, SLOT=32, BCLK_DIV=4 (256 clk per frame).
module tb_i2s_master_ctrl;
`ifdef I2S_REPEAT_ON_UNDERRUN_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, bclk_o, lrclk_o, dacda_o, frame_start, underrun, busy;
    int          n_vec = 0;
    int          n_err = 0;

    i2s_master_ctrl #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .bclk_o(bclk_o), .lrclk_o(lrclk_o),
        .dacda_o(dacda_o), .frame_start(frame_start), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic dexp(input logic [15:0] l, input logic [15:0] r, input int b);
        logic [15:0] w;
        int c;
        w = (b < 32) ? l : r;
        c = b % 32;
        return (c < 16) ? w[15-c] : 1'b0;
    endfunction

    function automatic logic lrexp(input int b);
        return (b >= 31) && (b <= 62);
    endfunction

    function automatic logic [15:0] sl(input int k);
        return 16'hC000 | 16'(k);
    endfunction

    function automatic logic [15:0] sr(input int k);
        return 16'h0001 << k;
    endfunction

    // Entered at the negedge after a load edge; checks all 256 cycles of that frame.
    task automatic frame_chk(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic ur, input int drop, input int raise);
        logic [5:0] e;
        for (int n = 0; n < 256; n++) begin
            if (n > 0) @(negedge clk);
            e = {n == 0, ur && n == 0, 1'b1, (n % 4) >= 2, lrexp(n / 4), dexp(l, r, n / 4)};
            check($sformatf("%s n=%0d {fs,ur,busy,bclk,lr,da}", tag, n),
                  {26'd0, frame_start, underrun, busy, bclk_o, lrclk_o, dacda_o}, {26'd0, e});
            if (n == drop) enable = 1'b0;
            if (n == raise) enable = 1'b1;
        end
    endtask

    initial begin
        logic [6:0]  e7;
        logic [15:0] ul, urr;
        int          hs, k, pulses;
        repeat (2) @(negedge clk);
        check("reset {fs,ur,rdy,busy,bclk,lr,da}",
              {25'd0, frame_start, underrun, in_ready, busy, bclk_o, lrclk_o, dacda_o}, 32'h10);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle {fs,ur,rdy,busy,bclk,lr,da}",
              {25'd0, frame_start, underrun, in_ready, busy, bclk_o, lrclk_o, dacda_o}, 32'h10);

        // Preload then start: first frame carries the preloaded samples.
        left_in = 16'hA5C3; right_in = 16'h0F0F; in_valid = 1'b1;
        @(negedge clk);
        check("preload in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        check("post-load in_ready", {31'd0, in_ready}, 32'd1);
        frame_chk("f1", 16'hA5C3, 16'h0F0F, 1'b0, -1, -1);
        ul = REP ? 16'hA5C3 : 16'h0; urr = REP ? 16'h0F0F : 16'h0;
        @(negedge clk);
        frame_chk("f2_under", ul, urr, 1'b1, -1, -1);

        // Handshake coincident with a load from empty holding: underrun now, data next frame.
        left_in = 16'h1234; right_in = 16'h5678; in_valid = 1'b1;
        @(negedge clk);
        frame_chk("f3_coincide", ul, urr, 1'b1, -1, -1);
        check("f3 holding full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        frame_chk("f4_drain", 16'h1234, 16'h5678, 1'b0, 40, -1);
        @(negedge clk);
        check("drained {fs,ur,rdy,busy,bclk,lr,da}",
              {25'd0, frame_start, underrun, in_ready, busy, bclk_o, lrclk_o, dacda_o}, 32'h10);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_start || busy || bclk_o) pulses++;
        end
        check("idle activity after drain", pulses, 0);

        // Enable from IDLE with empty holding: underrun and frame_start together.
        ul = REP ? 16'h1234 : 16'h0; urr = REP ? 16'h5678 : 16'h0;
        enable = 1'b1;
        @(negedge clk);
        frame_chk("f5_idle_under", ul, urr, 1'b1, -1, -1);
        @(negedge clk);
        frame_chk("f6_drain_resume", ul, urr, 1'b1, 20, 160);
        @(negedge clk);
        frame_chk("f7_after_resume", ul, urr, 1'b1, -1, -1);

        // Streaming with in_valid held high.
        reset_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        left_in = sl(0); right_in = sr(0); in_valid = 1'b1;
        @(negedge clk);
        enable = 1'b1; left_in = sl(1); right_in = sr(1);
        @(negedge clk);
        hs = 0;
        for (int m = 0; m < 2048; m++) begin
            if (m > 0) @(negedge clk);
            k = m / 256;
            e7 = {m % 256 == 0, 1'b0, m % 256 == 0, 1'b1, (m % 4) >= 2,
                  lrexp((m % 256) / 4), dexp(sl(k), sr(k), (m % 256) / 4)};
            check($sformatf("stream m=%0d {fs,ur,rdy,busy,bclk,lr,da}", m),
                  {25'd0, frame_start, underrun, in_ready, busy, bclk_o, lrclk_o, dacda_o}, {25'd0, e7});
            if (in_valid && in_ready) hs++;
            if (m % 256 == 1) begin
                left_in = sl(k + 2); right_in = sr(k + 2);
            end
        end
        check("stream handshakes", hs, 8);

        // Asynchronous reset in the right slot, then a clean restart.
        repeat (150) @(negedge clk);
        check("pre-reset lrclk", {31'd0, lrclk_o}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0; in_valid = 1'b0; enable = 1'b0;
        #1 check("async reset {fs,ur,rdy,busy,bclk,lr,da}",
                 {25'd0, frame_start, underrun, in_ready, busy, bclk_o, lrclk_o, dacda_o}, 32'h10);
        @(negedge clk);
        reset_n = 1'b1;
        left_in = 16'hF00F; right_in = 16'h8000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        frame_chk("restart", 16'hF00F, 16'h8000, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
